// File: rtl/tb_fb_cpu.sv
// Accumulator CPU with a private word-addressed RAM: fetch/latch/decode/execute
// control, program load through the reset-time load port, debug read-back port.
module tb_fb_cpu #(
    parameter int ADDRESS_WIDTH = 6,
    parameter int DATA_WIDTH    = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_en,
    input  logic [ADDRESS_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0]    load_data,
    input  logic [ADDRESS_WIDTH-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0]    dbg_data,
    output logic [ADDRESS_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0]    acc,
    output logic [2:0]               state,
    output logic                     halted
);

    localparam int DEPTH = 1 << ADDRESS_WIDTH;
    localparam int OP_W  = DATA_WIDTH - ADDRESS_WIDTH;

    localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_MUL   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_DIV   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_JMP   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_JZ    = OP_W'(7);
    localparam logic [OP_W-1:0] OP_HALT  = OP_W'(9);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_LATCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t                   state_q, state_nx;
    logic [ADDRESS_WIDTH-1:0] pc_q, pc_nx;
    logic [DATA_WIDTH-1:0]    acc_q, acc_nx;
    logic [DATA_WIDTH-1:0]    ir_q, ir_nx;
    logic [ADDRESS_WIDTH-1:0] mar;
    logic                     store_we;

    logic [DATA_WIDTH-1:0]    mem [DEPTH];
    logic [DATA_WIDTH-1:0]    rdata;
    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]    mem_wdata;

    logic [OP_W-1:0]          op;
    logic [ADDRESS_WIDTH-1:0] operand;

    assign op      = ir_q[DATA_WIDTH-1:ADDRESS_WIDTH];
    assign operand = ir_q[ADDRESS_WIDTH-1:0];

    // Reset owns the write port: the load strobe only counts under rst, and a
    // STORE caught in the same cycle as rst is dropped.
    assign mem_we    = rst ? load_en   : store_we;
    assign mem_addr  = rst ? load_addr : operand;
    assign mem_wdata = rst ? load_data : acc_q;

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_addr] <= mem_wdata;
        rdata <= mem[mar];
    end

    assign dbg_data = mem[dbg_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            acc_q   <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_nx;
            pc_q    <= pc_nx;
            acc_q   <= acc_nx;
            ir_q    <= ir_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        pc_nx    = pc_q;
        acc_nx   = acc_q;
        ir_nx    = ir_q;
        mar      = pc_q;
        store_we = 1'b0;
        case (state_q)
            S_FETCH: begin
                mar      = pc_q;
                state_nx = S_LATCH;
            end
            S_LATCH: begin
                ir_nx    = rdata;
                pc_nx    = pc_q + 1'b1;
                state_nx = S_DECODE;
            end
            S_DECODE: begin
                state_nx = S_FETCH;
                if (op <= OP_DIV) begin
                    // Operand read is issued now so rdata is ready in execute.
                    mar      = operand;
                    state_nx = S_EXEC;
                end else if (op == OP_JMP) begin
                    pc_nx = operand;
                end else if (op == OP_JZ) begin
                    if (acc_q == '0)
                        pc_nx = operand;
                end else if (op == OP_HALT) begin
                    state_nx = S_HALT;
                end
            end
            S_EXEC: begin
                state_nx = S_FETCH;
                case (op)
                    OP_LOAD:  acc_nx = rdata;
                    OP_STORE: store_we = 1'b1;
                    OP_ADD:   acc_nx = acc_q + rdata;
                    OP_SUB:   acc_nx = acc_q - rdata;
                    OP_MUL:   acc_nx = acc_q * rdata;
                    OP_DIV:   acc_nx = (rdata == '0) ? '1 : acc_q / rdata;
                    default:  ;
                endcase
            end
            S_HALT:  state_nx = S_HALT;
            default: state_nx = S_FETCH;
        endcase
    end

    assign pc     = pc_q;
    assign acc    = acc_q;
    assign state  = state_q;
    assign halted = (state_q == S_HALT);

endmodule

// File: tb/tb_tb_fb_cpu.sv
// Bench for tb_fb_cpu: hand-computed program table, reset/wrap corner sequences,
// and random programs checked against an instruction-level model.
module tb_tb_fb_cpu;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_en;
    logic [5:0] load_addr;
    logic [9:0] load_data;
    logic [5:0] dbg_addr;
    logic [9:0] dbg_data;
    logic [5:0] pc;
    logic [9:0] acc;
    logic [2:0] state;
    logic       halted;

    always #5 clk = ~clk;

    tb_fb_cpu #(.ADDRESS_WIDTH(6), .DATA_WIDTH(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .pc        (pc),
        .acc       (acc),
        .state     (state),
        .halted    (halted)
    );

    typedef struct packed {
        int             n;
        logic [5:0][15:0] words;   // {addr[5:0], data[9:0]}
        int             exp_acc;
        int             exp_pc;
        int             exp_cyc;
        int             chk_addr;
        int             chk_data;
    } vec_t;

    int         nvec = 0;
    int         nerr = 0;
    logic [9:0] img [64];
    logic [9:0] mm  [64];
    int         m_acc, m_pc, m_cyc;
    vec_t       tbl [10];

    function automatic logic [15:0] w(input int a, input int d);
        return {6'(a), 10'(d)};
    endfunction

    function automatic vec_t mk(input int n, input logic [15:0] w0, w1, w2, w3, w4, w5,
                                input int ea, input int ep, input int ec,
                                input int ca, input int cd);
        vec_t v;
        v.n = n;
        v.words[0] = w0; v.words[1] = w1; v.words[2] = w2;
        v.words[3] = w3; v.words[4] = w4; v.words[5] = w5;
        v.exp_acc = ea; v.exp_pc = ep; v.exp_cyc = ec;
        v.chk_addr = ca; v.chk_data = cd;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic read_mem(input int a, output int d);
        dbg_addr = 6'(a);
        #1;
        d = int'(dbg_data);
    endtask

    // Writes img into RAM under reset, checks reset state, releases reset at a negedge.
    task automatic load_image(input string tag);
        @(negedge clk);
        rst = 1'b1;
        load_en = 1'b1;
        for (int a = 0; a < 64; a++) begin
            load_addr = 6'(a);
            load_data = img[a];
            @(negedge clk);
        end
        load_en = 1'b0;
        chk({tag, "_rst_state"}, int'(state), 0);
        chk({tag, "_rst_pc"}, int'(pc), 0);
        chk({tag, "_rst_acc"}, int'(acc), 0);
        chk({tag, "_rst_halted"}, int'(halted), 0);
        rst = 1'b0;
    endtask

    task automatic run_to_halt(output int cyc);
        cyc = 0;
        while (!halted && cyc < 500) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
    endtask

    // Instruction-level reference: one step per instruction, cycle cost by class.
    task automatic model();
        bit done = 0;
        for (int a = 0; a < 64; a++) mm[a] = img[a];
        m_acc = 0; m_pc = 0; m_cyc = 0;
        for (int k = 0; k < 1000 && !done; k++) begin
            int op, opd, v;
            op  = int'(mm[m_pc]) / 64;
            opd = int'(mm[m_pc]) % 64;
            m_pc = (m_pc + 1) % 64;
            v = int'(mm[opd]);
            m_cyc += (op <= 5) ? 4 : 3;
            case (op)
                0: m_acc = v;
                1: mm[opd] = 10'(m_acc);
                2: m_acc = (m_acc + v) % 1024;
                3: m_acc = (m_acc + 1024 - v) % 1024;
                4: m_acc = (m_acc * v) % 1024;
                5: m_acc = (v == 0) ? 1023 : m_acc / v;
                6: m_pc = opd;
                7: if (m_acc == 0) m_pc = opd;
                9: done = 1;
                default: ;
            endcase
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc, d, hpc, hacc;
        string t;
        t = $sformatf("v%0d", idx);
        for (int a = 0; a < 64; a++) img[a] = '0;
        for (int j = 0; j < v.n; j++) img[v.words[j][15:10]] = v.words[j][9:0];
        load_image(t);
        run_to_halt(cyc);
        chk({t, "_cycles"}, cyc, v.exp_cyc);
        chk({t, "_halted"}, int'(halted), 1);
        chk({t, "_acc"}, int'(acc), v.exp_acc);
        chk({t, "_pc"}, int'(pc), v.exp_pc);
        read_mem(v.chk_addr, d);
        chk({t, "_mem"}, d, v.chk_data);
        hpc = int'(pc); hacc = int'(acc);
        repeat (4) @(negedge clk);
        chk({t, "_hold_pc"}, int'(pc), hpc);
        chk({t, "_hold_acc"}, int'(acc), hacc);
        chk({t, "_hold_state"}, int'(state), 4);
    endtask

    initial begin
        int cyc, d;
        rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0; dbg_addr = '0;

        tbl[0] = mk(6, w(0,10), w(1,139), w(2,76), w(3,576), w(10,5), w(11,7), 12, 4, 15, 12, 12);
        tbl[1] = mk(3, w(0,0), w(1,453), w(5,576), 0, 0, 0, 0, 6, 10, 1, 453);
        tbl[2] = mk(5, w(0,10), w(1,203), w(2,576), w(10,3), w(11,5), 0, 1022, 3, 11, 11, 5);
        tbl[3] = mk(6, w(0,10), w(1,267), w(2,76), w(3,576), w(10,40), w(11,30), 176, 4, 15, 12, 176);
        tbl[4] = mk(5, w(0,10), w(1,331), w(2,576), w(10,9), w(11,0), 0, 1023, 3, 11, 10, 9);
        tbl[5] = mk(5, w(0,10), w(1,332), w(2,576), w(10,9), w(12,2), 0, 4, 3, 11, 12, 2);
        tbl[6] = mk(5, w(0,10), w(1,453), w(2,576), w(5,576), w(10,7), 0, 7, 3, 10, 10, 7);
        tbl[7] = mk(4, w(0,404), w(20,512), w(21,963), w(22,576), 0, 0, 0, 23, 12, 3, 0);
        tbl[8] = mk(4, w(0,511), w(1,576), w(10,5), w(63,10), 0, 0, 5, 2, 13, 63, 10);
        tbl[9] = mk(5, w(0,10), w(1,139), w(2,576), w(10,1000), w(11,100), 0, 76, 3, 11, 11, 100);

        for (int i = 0; i < 10; i++) run_vec(tbl[i], i);

        // pc wraps 63 -> 0 in the latch state, then JMP 0 keeps it at 0
        for (int a = 0; a < 64; a++) img[a] = '0;
        img[0] = 10'd447; img[63] = 10'd384;
        load_image("wrap");
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("wrap_pc63", int'(pc), 63);
        @(posedge clk); @(negedge clk);
        chk("wrap_pc0", int'(pc), 0);
        chk("wrap_state2", int'(state), 2);
        @(posedge clk); @(negedge clk);
        chk("wrap_jmp_pc", int'(pc), 0);
        chk("wrap_jmp_state", int'(state), 0);

        // reset landing on the execute cycle of a STORE must suppress the write
        for (int a = 0; a < 64; a++) img[a] = '0;
        img[0] = 10'd10; img[1] = 10'd76; img[2] = 10'd576; img[10] = 10'd100; img[12] = 10'd333;
        load_image("st");
        repeat (7) @(posedge clk);
        @(negedge clk);
        chk("st_in_exec", int'(state), 3);
        chk("st_acc", int'(acc), 100);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("st_rst_state", int'(state), 0);
        chk("st_rst_pc", int'(pc), 0);
        chk("st_rst_acc", int'(acc), 0);
        read_mem(12, d);
        chk("st_rst_mem", d, 333);
        rst = 1'b0;
        // load strobe outside reset is ignored
        load_en = 1'b1; load_addr = 6'd12; load_data = 10'd5;
        repeat (2) @(negedge clk);
        load_en = 1'b0;
        read_mem(12, d);
        chk("st_load_ignored", d, 333);
        run_to_halt(cyc);
        chk("st_rerun_cycles", cyc + 2, 11);
        read_mem(12, d);
        chk("st_rerun_mem", d, 100);
        // reset from halted
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("hrst_state", int'(state), 0);
        chk("hrst_halted", int'(halted), 0);
        chk("hrst_pc", int'(pc), 0);
        chk("hrst_acc", int'(acc), 0);
        read_mem(12, d);
        chk("hrst_mem", d, 100);

        // random forward-only programs: code 0..15, HALT at 16, data 32..63
        for (int r = 0; r < 20; r++) begin
            for (int a = 0; a < 64; a++) img[a] = '0;
            for (int i = 0; i < 16; i++) begin
                int op, opd;
                op = int'($urandom_range(0, 15));
                if (op <= 5)                opd = int'($urandom_range(32, 63));
                else if (op == 6 || op == 7) opd = int'($urandom_range(i + 1, 16));
                else                        opd = int'($urandom_range(0, 63));
                img[i] = 10'(op * 64 + opd);
            end
            img[16] = 10'd576;
            for (int a = 32; a < 64; a++)
                img[a] = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(0, 1023));
            model();
            load_image($sformatf("r%0d", r));
            run_to_halt(cyc);
            chk($sformatf("r%0d_cycles", r), cyc, m_cyc);
            chk($sformatf("r%0d_acc", r), int'(acc), m_acc);
            chk($sformatf("r%0d_pc", r), int'(pc), m_pc);
            for (int a = 0; a < 64; a++) begin
                read_mem(a, d);
                chk($sformatf("r%0d_mem%0d", r, a), d, int'(mm[a]));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/tb_fb_cpu.md
TB_FB_CPU -- requirements
Module: tb_fb_cpu

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 6, SHALL set the memory address width and the PC width.
REQ-002 Parameter DATA_WIDTH, default 10, SHALL set the memory word, IR and ACC width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 load_en  input  1  SHALL be the program-load write strobe, honoured only while rst=1.
REQ-006 load_addr  input  ADDRESS_WIDTH  SHALL be the program-load word address.
REQ-007 load_data  input  DATA_WIDTH  SHALL be the program-load word.
REQ-008 dbg_addr  input  ADDRESS_WIDTH  SHALL be the memory read-back address.
REQ-009 dbg_data  output  DATA_WIDTH  SHALL present mem[dbg_addr] combinationally.
REQ-010 pc  output  ADDRESS_WIDTH  SHALL be the program counter.
REQ-011 acc  output  DATA_WIDTH  SHALL be the accumulator.
REQ-012 state  output  3  SHALL be the control state (0-4).
REQ-013 halted  output  1  SHALL be 1 exactly when state=4.

Function
REQ-014 Block SHALL contain a CPU core and a 64x10 RAM; RAM write synchronous (we, addr, wdata); RAM read registered: rdata <= mem[MAR] each rising edge.
REQ-015 Instruction SHALL be opcode=IR[9:6], operand address=IR[5:0].
REQ-016 State 0 (fetch) SHALL drive MAR=pc, then go to 1.
REQ-017 State 1 SHALL latch IR<=rdata, pc<=pc+1 (6-bit wrap, 63->0), then go to 2.
REQ-018 State 2 SHALL decode: opcode 0-5 -> MAR=IR[5:0], go to 3; 6 (JMP) -> pc<=IR[5:0], go to 0; 7 (JZ) -> if acc=0 then pc<=IR[5:0], go to 0; 8 (NOP) -> go to 0; 9 (HALT) -> go to 4; 10-15 -> treated as NOP, go to 0.
REQ-019 State 3 SHALL execute and go to 0: 0 LOAD acc<=rdata; 1 STORE mem[IR[5:0]]<=acc; 2 ADD acc<=acc+rdata; 3 SUB acc<=acc-rdata; 4 MUL acc<=acc*rdata; 5 DIV acc<=acc/rdata (unsigned integer).
REQ-020 All arithmetic SHALL be unsigned, results truncated to low 10 bits (ADD/SUB wrap mod 1024, MUL keeps low 10 bits).
REQ-021 DIV by zero SHALL set acc to 10'h3FF.
REQ-022 State 4 SHALL hold indefinitely (pc, acc, memory frozen) until rst.
REQ-023 Memory SHALL be written only by STORE in state 3 or by load port during reset; at most one write per cycle.
REQ-024 Latency SHALL be: LOAD/STORE/ALU 4 cycles; JMP/JZ/NOP/undefined 3 cycles; HALT 3 cycles to reach state 4.

Reset
REQ-025 rst=1 at a rising edge SHALL set state=0, pc=0, IR=0, acc=0, halted=0, regardless of current state (including mid-instruction or halted).
REQ-026 Memory contents SHALL NOT be cleared by reset; during rst=1 with load_en=1, mem[load_addr]<=load_data at each edge.
REQ-027 No STORE write SHALL occur in any cycle with rst=1.
REQ-028 Execution SHALL begin with fetch from address 0 on the first edge after rst deasserts.

Verification
REQ-029 Load mem[0]=10, mem[1]=139, mem[2]=76, mem[3]=576, mem[10]=5, mem[11]=7; release rst -> after 15 cycles halted=1, acc=12, mem[12]=12, pc=4.
REQ-030 mem[0]=0 (LOAD 0), mem[1]=448+5 (JZ 5), mem[5]=576 -> acc=0 after LOAD, jump taken, halted with pc=6.
REQ-031 acc=3, SUB operand 5 -> acc=1022; acc=40, MUL operand 30 -> acc=1200 mod 1024=176.
REQ-032 acc=9, DIV operand holding 0 -> acc=1023; DIV operand 2 -> acc=4.
REQ-033 mem[63]=384+0 (JMP 0) reached by wrap: pc fetch at 63 -> pc becomes 0 after state 1, then 0 after JMP.
REQ-034 Assert rst while halted or in state 3 of a STORE -> next edge state=0, pc=0, acc=0, target memory word unchanged.
